// File: rtl/mdu_pkg.sv
// mdu_pkg: shared pipeline constants for the multiply/divide unit.
// Holds the E-stage MDU op codes used by the decoder, the stall unit and the
// MDU itself, plus the counter width and the multi-cycle op classifier.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU to the long-op set).
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10
    } mdu_op_e;

    localparam int CNT_W = 16;

    // Ops that occupy the unit for several cycles (issue raises Start).
    function automatic logic is_long_op(input mdu_op_e op);
        case (op)
            MULT, MULTU, DIV, DIVU: is_long_op = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU:            is_long_op = 1'b1;
`endif
            default:                is_long_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_mult_class(input mdu_op_e op);
        is_mult_class = (op == MULT) || (op == MULTU) || (op == MADD) || (op == MADDU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result of a latched MDU op.
// Ports:
//   op_i        latched op code
//   a_i, b_i    latched operands
//   hi_i, lo_i  current HI/LO (accumulator input for MADD, kept on div-by-zero)
//   hi_o, lo_o  values to be written into HI/LO when the op completes
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate).
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdu_op_e     op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op = mdu_op_e'(op_i);

    // Signed product taken as the low 64 bits of the sign-extended operands.
    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign sgn   = (op == DIV);
    assign a_mag = (sgn && a_i[31]) ? -a_i : a_i;
    assign b_mag = (b_i == 32'd0) ? 32'd1 : ((sgn && b_i[31]) ? -b_i : b_i);
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quot  = (sgn && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
    assign rem   = (sgn && a_i[31]) ? -r_mag : r_mag;

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        case (op)
            MULT:  {hi_o, lo_o} = prod_s;
            MULTU: {hi_o, lo_o} = prod_u;
            DIV, DIVU: begin
                if (b_i != 32'd0) begin
                    hi_o = rem;
                    lo_o = quot;
                end
            end
`ifdef MDU_MADD_EN
            MADD:  {hi_o, lo_o} = {hi_i, lo_i} + prod_s;
            MADDU: {hi_o, lo_o} = {hi_i, lo_i} + prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit holding HI/LO, the busy down-counter and the
// latched operands of the op in flight.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   Op     E-stage MDU op code (mdu_pkg::mdu_op_e)
//   A, B   forwarded rs / rt values
//   Req    exception/interrupt flush, cancels the E-stage op
//   Start  a long op is issued this cycle
//   Busy   a long op is in progress
//   Out    HI for MFHI, LO for MFLO, otherwise 0
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate ops).
//
// state  | meaning
// S_IDLE | no op in flight; long ops issue, MTHI/MTLO write
// S_BUSY | counting down; HI/LO written at terminal count
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] Out
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    mdu_op_e          op;

    assign op    = mdu_op_e'(Op);
    assign Busy  = (state_q == S_BUSY);
    assign Start = is_long_op(op) && !Req && !Busy;

    always_comb begin
        case (op)
            MFHI:    Out = hi_q;
            MFLO:    Out = lo_q;
            default: Out = 32'd0;
        endcase
    end

    mdu_calc u_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_mult_class(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d = S_BUSY;
                end else if (!Req) begin
                    if (op == MTHI) hi_d = A;
                    if (op == MTLO) lo_d = A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = calc_hi;
                    lo_d    = calc_lo;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
